ps2_rx_fifo_receiver: RTL and testbench

Parametrised next-generation PS/2 device-to-host receiver. Synchronises and glitch-filters ps2_clk/ps2_data, samples on a selectable edge, and decodes the full 11-bit frame (start, 8 data LSB-first, odd parity, stop). Provides parity, framing and timeout error reporting, and buffers good bytes in a FWFT FIFO with a valid/ready handshake. Sits between the PS/2 pads and downstream keycode decode logic such as the morse encoder front end.

---
 rtl/ps2_rx_fifo_receiver_pkg.sv | 21 ++
 rtl/ps2_rx_fifo_receiver_if.sv | 28 ++
 rtl/ps2_rx_fifo_receiver_line_filter.sv | 42 ++++
 rtl/ps2_rx_fifo_receiver.sv | 168 ++++++++++++++++
 tb/tb_ps2_rx_fifo_receiver.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_rx_fifo_receiver_pkg.sv
// Shared constants for the PS/2 receiver: FSM encoding,
// frame geometry and the odd-parity check.
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // True when data plus parity hold an odd number of ones.
  function automatic logic parity_ok(
    input logic [PS2_DATA_BITS-1:0] d,
    input logic                     p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_receiver_if.sv
// Byte stream handshake out of the receiver FIFO.
// master: rx_data/rx_valid/rx_level out, rx_ready in.
interface ps2_rx_fifo_receiver_if #(
  parameter int FIFO_DEPTH = 4
) ();

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [LW-1:0] rx_level;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_level,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_level,
    output rx_ready
  );

endinterface

// File: rtl/ps2_rx_fifo_receiver_line_filter.sv
// Synchroniser plus stability filter for one PS/2 line.
// Ports: clk, rst, pad (async in), line (filtered out).
module ps2_line_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic line
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s_out;

  assign s_out = sync[SYNC_STAGES-1];

  // cnt counts consecutive synchronised samples that
  // disagree with the filtered line; any agreement resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{RST_VAL}};
      cnt  <= '0;
      line <= RST_VAL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad};
      if (s_out == line) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        line <= s_out;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo_receiver.sv
// PS/2 device-to-host receiver with frame decode, error
// pulses and a FWFT byte FIFO on the rx handshake port.
module ps2_rx_fifo_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int SAMPLE_EDGE    = 0,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  ps2_rx_fifo_receiver_if.master rx,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   timeout_err,
  output logic                   overflow,
  output logic                   busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DB = PS2_DATA_BITS;

  logic clk_f, data_f, clk_q, strobe;

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .RST_VAL    (1'b1)
  ) u_clk_filt (
    .clk (clk),
    .rst (rst),
    .pad (ps2_clk),
    .line(clk_f)
  );

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .RST_VAL    (1'b1)
  ) u_data_filt (
    .clk (clk),
    .rst (rst),
    .pad (ps2_data),
    .line(data_f)
  );

  assign strobe = (SAMPLE_EDGE != 0) ?
                  (clk_f & ~clk_q) :
                  (~clk_f & clk_q);

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [DB-1:0] shreg;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          push;

  assign busy = (state != ST_IDLE);

  // The stop strobe pushes straight into the FIFO so the
  // byte is visible on the very next cycle.
  assign push = strobe && (state == ST_STOP) &&
                data_f && parity_ok(shreg, par);

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_q       <= 1'b1;
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      to_cnt      <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      clk_q       <= clk_f;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      if (strobe) begin
        to_cnt <= '0;
        unique case (1'b1)
          (state == ST_IDLE): begin
            if (!data_f) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
              shreg   <= '0;
            end
          end
          (state == ST_DATA): begin
            shreg[bit_cnt] <= data_f;
            bit_cnt        <= bit_cnt + 1'b1;
            if (bit_cnt == 3'(DB - 1))
              state <= ST_PARITY;
          end
          (state == ST_PARITY): begin
            par   <= data_f;
            state <= ST_STOP;
          end
          (state == ST_STOP): begin
            state <= ST_IDLE;
            // A bad stop bit masks a parity error.
            if (!data_f)
              frame_err <= 1'b1;
            else if (!parity_ok(shreg, par))
              parity_err <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state == ST_IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        to_cnt      <= '0;
        state       <= ST_IDLE;
        timeout_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  logic [DB-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          full, pop, push_ok;

  assign full    = (count == LW'(FIFO_DEPTH));
  assign pop     = rx.rx_valid & rx.rx_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push & (~full | pop);

  assign rx.rx_valid = (count != '0);
  assign rx.rx_level = count;
  assign rx.rx_data  = rx.rx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & ~push_ok;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo_receiver.sv
// Scoreboard bench: stimulus queues expected frame outcomes,
// a negedge monitor matches them against DUT pulses and FIFO.
module tb_ps2_rx_fifo_receiver;

  localparam int DEPTH = 4;
  localparam int TO    = 200;
  localparam int HALF  = 15;

  localparam int EV_GOOD = 0;
  localparam int EV_PAR  = 1;
  localparam int EV_FRM  = 2;
  localparam int EV_TO   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic parity_err, frame_err, timeout_err;
  logic overflow, busy;

  ps2_rx_fifo_receiver_if #(.FIFO_DEPTH(DEPTH)) rx_if ();

  ps2_rx_fifo_receiver #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (4),
    .SAMPLE_EDGE   (0),
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx         (rx_if),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] mq[$];
  int checks   = 0;
  int failures = 0;
  int rdy_mode = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d",
               name, act, exp);
    end
  endtask

  initial begin
    rx_if.rx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rx_if.rx_ready = 1'b1;
        1:       rx_if.rx_ready = 1'($urandom_range(0, 1));
        default: rx_if.rx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: mq is the ideal FIFO after last cycle's pop.
  int         pv;
  ev_t        e;
  logic [7:0] h;
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      pv = int'({overflow, timeout_err,
                 frame_err, parity_err});
      if (pv != 0 || int'(rx_if.rx_level) != mq.size()) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", pv * 16 +
              int'(rx_if.rx_level), mq.size());
        end else begin
          e = exp_q.pop_front();
          case (e.kind)
            EV_GOOD: begin
              if (mq.size() < DEPTH) begin
                chk("push_level", int'(rx_if.rx_level),
                    mq.size() + 1);
                chk("push_pulses", pv, 0);
                mq.push_back(e.d);
              end else begin
                chk("ovf_pulses", pv, 8);
                chk("ovf_level", int'(rx_if.rx_level), DEPTH);
              end
            end
            EV_PAR: begin
              chk("parity_pulses", pv, 1);
              chk("parity_level", int'(rx_if.rx_level),
                  mq.size());
            end
            EV_FRM: begin
              chk("frame_pulses", pv, 2);
              chk("frame_level", int'(rx_if.rx_level),
                  mq.size());
            end
            default: begin
              chk("timeout_pulses", pv, 4);
              chk("timeout_level", int'(rx_if.rx_level),
                  mq.size());
            end
          endcase
        end
      end
      chk("valid", int'(rx_if.rx_valid),
          int'(mq.size() != 0));
      if (rx_if.rx_valid && rx_if.rx_ready &&
          mq.size() > 0) begin
        h = mq.pop_front();
        chk("pop_data", int'(rx_if.rx_data), int'(h));
      end
    end
  end

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic b, bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cycles(6);
      ps2_clk = 1'b0;
      wait_cycles(2);
      ps2_clk = 1'b1;
      wait_cycles(HALF - 8);
    end else begin
      wait_cycles(HALF);
    end
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] d, bit bad_par,
                            bit bad_stop, bit glitch);
    logic [10:0] f;
    ev_t x;
    f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    x.d = d;
    x.kind = bad_stop ? EV_FRM :
             bad_par  ? EV_PAR : EV_GOOD;
    exp_q.push_back(x);
    for (int i = 0; i < 11; i++)
      send_bit(f[i], glitch);
    ps2_data = 1'b1;
    wait_cycles(40);
  endtask

  task automatic send_raw(logic [7:0] d, int nbits,
                          bit glitch);
    logic [10:0] f;
    f = {1'b1, ~^d, d, 1'b0};
    for (int i = 0; i < nbits; i++)
      send_bit(f[i], glitch);
    ps2_data = 1'b1;
  endtask

  task automatic send_partial(logic [7:0] d, int nbits,
                              bit glitch);
    ev_t x;
    x.kind = EV_TO;
    x.d = d;
    exp_q.push_back(x);
    send_raw(d, nbits, glitch);
    wait_cycles(TO + 60);
  endtask

  task automatic idle_glitch();
    wait_cycles(10);
    ps2_clk = 1'b0;
    wait_cycles(2);
    ps2_clk = 1'b1;
    wait_cycles(10);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mq.size() != 0) &&
           n < 3000) begin
      wait_cycles(1);
      n++;
    end
    chk("drain", exp_q.size() + mq.size(), 0);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(rx_if.rx_valid), 0);
    chk({tag, "_level"}, int'(rx_if.rx_level), 0);
    chk({tag, "_data"}, int'(rx_if.rx_data), 0);
    chk({tag, "_pulses"}, int'({overflow, timeout_err,
                                frame_err, parity_err}), 0);
  endtask

  initial begin
    rst = 1'b1;
    wait_cycles(5);
    chk_reset_outputs("reset");
    rst = 1'b0;
    wait_cycles(10);

    rdy_mode = 0;
    send_frame(8'h1C, 0, 0, 0);
    wait_drain();
    send_frame(8'h1C, 1, 0, 0);
    wait_drain();
    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h5A, 0, 0, 0);
    send_frame(8'h33, 1, 1, 0);
    wait_drain();

    begin
      ev_t x;
      x.kind = EV_TO;
      x.d = 8'h00;
      exp_q.push_back(x);
      send_raw(8'h55, 4, 0);
      wait_cycles(5);
      chk("partial_busy", int'(busy), 1);
      wait_cycles(TO + 60);
      chk("timeout_busy", int'(busy), 0);
    end
    send_frame(8'h29, 0, 0, 0);
    wait_drain();

    rdy_mode = 2;
    wait_cycles(2);
    for (int i = 1; i <= 5; i++)
      send_frame(8'(i), 0, 0, 0);
    wait_cycles(10);
    chk("full_level", int'(rx_if.rx_level), DEPTH);
    rdy_mode = 0;
    wait_drain();

    idle_glitch();
    send_frame(8'h76, 0, 0, 1);
    idle_glitch();
    wait_drain();

    rdy_mode = 2;
    send_frame(8'h42, 0, 0, 0);
    wait_cycles(5);
    chk("pre_reset_level", int'(rx_if.rx_level), 1);
    send_raw(8'h76, 5, 1);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(3);
    chk_reset_outputs("midreset");
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(20);
    rst = 1'b0;
    rdy_mode = 0;
    wait_cycles(20);
    chk_reset_outputs("post_reset");
    send_frame(8'h76, 0, 0, 1);
    wait_drain();

    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int r;
      bit g;
      logic [7:0] d;
      r = $urandom_range(0, 9);
      g = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (r < 6)
        send_frame(d, 0, 0, g);
      else if (r == 6)
        send_frame(d, 1, 0, g);
      else if (r == 7)
        send_frame(d, 0, 1, g);
      else if (r == 8)
        send_frame(d, 1, 1, g);
      else
        send_partial(d, $urandom_range(1, 10), g);
    end
    rdy_mode = 0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
